// File: rtl/osd_text_layer_if.sv
`default_nettype none
// ============================================================================
// osd_text_layer_if: host character-write and commit port of the text overlay
// Rev 1.0
// ============================================================================
interface osd_text_layer_if #(
  parameter int LINES = 10,
  parameter int COLS  = 20
) ();
  logic                     wr_en;
  logic [$clog2(LINES)-1:0] wr_line;
  logic [$clog2(COLS)-1:0]  wr_col;
  logic [7:0]               wr_char;
  logic                     commit;
  logic                     commit_pend;

  modport master (output wr_en, wr_line, wr_col, wr_char, commit, input commit_pend);
  modport slave  (input wr_en, wr_line, wr_col, wr_char, commit, output commit_pend);
endinterface
`default_nettype wire

// File: rtl/osd_text_layer.sv
`default_nettype none
// ============================================================================
// osd_text_layer: double-buffered LINES x COLS text overlay on the pixel stream
// Rev 1.0
// ============================================================================
module osd_text_layer #(
  parameter int          LINES      = 10,
  parameter int          COLS       = 20,
  parameter int          X_START    = 50,
  parameter int          Y_START    = 50,
  parameter int          LINE_PITCH = 50,
  parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [23:0] i_data,
  input  logic        scale2x,
  input  logic        opaque,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [23:0] o_data,
  osd_text_layer_if.slave host
);
  localparam int NCELL = LINES * COLS;
  localparam int AW    = $clog2(NCELL + COLS);
  localparam int CLW   = $clog2(COLS);
  localparam int VLW   = $clog2(LINES + 1);
  localparam int VPW   = $clog2(LINE_PITCH + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PEND = 1'b1} commit_state_t;

  commit_state_t state, state_nx;
  logic          swap, front;

  logic           vs_q, de_q, synced, scale_f, opaque_f;
  logic [11:0]    x_cnt, y_cnt;
  logic           h_in;
  logic [CLW-1:0] h_col;
  logic [3:0]     h_sub;
  logic           v_start;
  logic [VPW-1:0] v_pit;
  logic [VLW-1:0] v_line;
  logic [AW-1:0]  v_base;

  logic [7:0] buf0 [NCELL];
  logic [7:0] buf1 [NCELL];

  logic [7:0]  ch_q;
  logic [3:0]  row_q;
  logic [2:0]  col_q, col2;
  logic        in_q, in2;
  logic        hs1, vs1, de1, hs2, vs2, de2;
  logic [23:0] data1, data2;

  wire vs_rise = i_vs & ~vs_q;
  wire de_fall = de_q & ~i_de;

  wire [3:0]     cw_last    = scale_f ? 4'd15 : 4'd7;
  wire [VPW-1:0] ch_rows    = scale_f ? VPW'(32) : VPW'(16);
  wire           v_in       = v_start && (32'(v_line) < LINES) && (v_pit < ch_rows);
  wire           in_cell    = synced & i_de & h_in & v_in;
  wire [AW-1:0]  rd_addr    = v_base + AW'(h_col);
  wire [3:0]     glyph_row  = scale_f ? v_pit[4:1] : v_pit[3:0];
  wire [2:0]     bit_col    = scale_f ? h_sub[3:1] : h_sub[2:0];

  wire          wr_ok   = host.wr_en && (32'(host.wr_line) < LINES) && (32'(host.wr_col) < COLS);
  wire [AW-1:0] wr_addr = AW'(host.wr_line) * AW'(COLS) + AW'(host.wr_col);

  // Running position trackers: each register describes the pixel currently on i_*.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0; de_q <= 1'b0; synced <= 1'b0; scale_f <= 1'b0; opaque_f <= 1'b0;
      x_cnt <= '0; y_cnt <= '0;
      h_in <= 1'b0; h_col <= '0; h_sub <= '0;
      v_start <= 1'b0; v_pit <= '0; v_line <= '0; v_base <= '0;
    end else begin
      vs_q  <= i_vs;
      de_q  <= i_de;
      x_cnt <= (i_de && !vs_rise) ? x_cnt + 12'd1 : 12'd0;

      if (!i_de) begin
        h_in  <= (X_START == 0);
        h_col <= '0;
        h_sub <= '0;
      end else if (h_in) begin
        if (h_sub == cw_last) begin
          h_sub <= '0;
          if (32'(h_col) == COLS - 1) h_in <= 1'b0;
          else                        h_col <= h_col + 1'b1;
        end else begin
          h_sub <= h_sub + 4'd1;
        end
      end else if (x_cnt + 12'd1 == 12'(X_START)) begin
        h_in  <= 1'b1;
        h_col <= '0;
        h_sub <= '0;
      end

      if (vs_rise) begin
        synced   <= 1'b1;
        scale_f  <= scale2x;
        opaque_f <= opaque;
        y_cnt    <= '0;
        v_start  <= (Y_START == 0);
        v_pit    <= '0;
        v_line   <= '0;
        v_base   <= '0;
      end else if (de_fall) begin
        y_cnt <= y_cnt + 12'd1;
        if (v_start) begin
          if (32'(v_pit) == LINE_PITCH - 1) begin
            v_pit <= '0;
            if (32'(v_line) < LINES) begin
              v_line <= v_line + 1'b1;
              v_base <= v_base + AW'(COLS);
            end
          end else begin
            v_pit <= v_pit + VPW'(1);
          end
        end else if (y_cnt + 12'd1 == 12'(Y_START)) begin
          v_start <= 1'b1;
          v_pit   <= '0;
          v_line  <= '0;
          v_base  <= '0;
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      front <= 1'b0;
    end else begin
      state <= state_nx;
      if (swap) front <= ~front;
    end
  end

  always_comb begin
    state_nx = state;
    swap     = 1'b0;
    case (state)
      ST_IDLE: if (host.commit) state_nx = ST_PEND;
      ST_PEND: if (vs_rise) begin
        state_nx = ST_IDLE;
        swap     = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign host.commit_pend = (state == ST_PEND);

  // Host writes always land in the buffer that is not being displayed.
  always_ff @(posedge pclk) begin
    if (wr_ok) begin
      if (front) buf0[wr_addr] <= host.wr_char;
      else       buf1[wr_addr] <= host.wr_char;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q <= '0; row_q <= '0; col_q <= '0; in_q <= 1'b0;
      hs1 <= 1'b0; vs1 <= 1'b0; de1 <= 1'b0; data1 <= '0;
      col2 <= '0; in2 <= 1'b0;
      hs2 <= 1'b0; vs2 <= 1'b0; de2 <= 1'b0; data2 <= '0;
      o_hs <= 1'b0; o_vs <= 1'b0; o_de <= 1'b0; o_data <= '0;
    end else begin
      if (in_cell) ch_q <= front ? buf1[rd_addr] : buf0[rd_addr];
      row_q <= glyph_row;
      col_q <= bit_col;
      in_q  <= in_cell;
      hs1 <= i_hs; vs1 <= i_vs; de1 <= i_de; data1 <= i_data;

      col2 <= col_q;
      in2  <= in_q;
      hs2 <= hs1; vs2 <= vs1; de2 <= de1; data2 <= data1;

      o_hs <= hs2; o_vs <= vs2; o_de <= de2;
      if (in2 && font_data[3'd7 - col2]) o_data <= FG_COLOR;
      else if (in2 && opaque_f)          o_data <= BG_COLOR;
      else                               o_data <= data2;
    end
  end

  assign font_addr = {ch_q, row_q};
endmodule
`default_nettype wire

// File: tb/tb_osd_text_layer.sv
`default_nettype none
// ============================================================================
// tb_osd_text_layer: directed frames against a pixel model of the text overlay
// Rev 1.0
// ============================================================================
module tb_osd_text_layer;
  localparam int LINES = 10, COLS = 20, XS = 50, YS = 50, PITCH = 50;
  localparam int HA = 80, HT = 88, VA = 120, VSL = 2, VT = VA + VSL, N = VT * HT;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        i_hs, i_vs, i_de;
  logic [23:0] i_data;
  logic        scale2x, opaque;
  logic [11:0] font_addr;
  logic [7:0]  font_data = 8'h00;
  logic        o_hs, o_vs, o_de;
  logic [23:0] o_data;

  osd_text_layer_if #(.LINES(LINES), .COLS(COLS)) host_bus ();

  osd_text_layer #(
    .LINES(LINES), .COLS(COLS), .X_START(XS), .Y_START(YS), .LINE_PITCH(PITCH),
    .FG_COLOR(24'hFFFFFF), .BG_COLOR(24'h000000)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .scale2x(scale2x), .opaque(opaque), .font_addr(font_addr), .font_data(font_data),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data), .host(host_bus)
  );

  always #5 pclk = ~pclk;

  function automatic logic [7:0] rom(input logic [11:0] a);
    return a[11:4] ^ {a[3:0], a[3:0]} ^ 8'h5A;
  endfunction

  always @(posedge pclk) font_data <= rom(font_addr);

  int checks, errors, first_bad;
  int mfront, mdisp;
  bit mscale, mopaque;
  logic [23:0] fseed;
  logic [7:0]  mbuf [2][LINES*COLS];

  logic [23:0] in_data_a [N];
  logic        in_de_a [N], in_hs_a [N], in_vs_a [N];
  logic [23:0] cap_data [N+4];
  logic        cap_de [N+4], cap_hs [N+4], cap_vs [N+4], cap_pend [N+4];

  function automatic int pix(input int x, input int y);
    return (y + VSL) * HT + x;
  endfunction

  function automatic logic [23:0] exp_pix(input int n);
    int L, p, x, y, s, cw, chh, ly, ry, c;
    logic [7:0] chr, g;
    L = n / HT; p = n % HT;
    if (!(L >= VSL && p < HA)) return in_data_a[n];
    x = p; y = L - VSL;
    s = mscale ? 1 : 0; cw = 8 << s; chh = 16 << s;
    if (x < XS || y < YS) return in_data_a[n];
    ly = (y - YS) / PITCH; ry = (y - YS) % PITCH; c = (x - XS) / cw;
    if (ly >= LINES || ry >= chh || c >= COLS) return in_data_a[n];
    chr = mbuf[mdisp][ly*COLS + c];
    g = rom({chr, 4'(ry >> s)});
    if (g[7 - (((x - XS) % cw) >> s)]) return 24'hFFFFFF;
    return mopaque ? 24'h000000 : in_data_a[n];
  endfunction

  function automatic int data_errs();
    int e = 0;
    first_bad = -1;
    for (int n = 0; n < N; n++)
      if (cap_data[n+3] !== exp_pix(n)) begin
        e++;
        if (first_bad < 0) first_bad = n;
      end
    return e;
  endfunction

  function automatic int sync_errs();
    int e = 0;
    for (int n = 0; n < N; n++)
      if (cap_de[n+3] !== in_de_a[n] || cap_hs[n+3] !== in_hs_a[n] || cap_vs[n+3] !== in_vs_a[n]) e++;
    return e;
  endfunction

  task automatic run_frame(input bit commit_first);
    int L, p;
    for (int n = 0; n < N + 4; n++) begin
      @(posedge pclk); #1;
      cap_data[n] = o_data; cap_de[n] = o_de; cap_hs[n] = o_hs; cap_vs[n] = o_vs;
      cap_pend[n] = host_bus.commit_pend;
      if (n < N) begin
        L = n / HT; p = n % HT;
        i_vs = (L < VSL);
        i_hs = (p >= HA + 2 && p < HA + 6);
        i_de = (L >= VSL && p < HA);
        i_data = fseed + 24'(n);
        host_bus.commit = commit_first && (n == 0);
        in_data_a[n] = i_data; in_de_a[n] = i_de; in_hs_a[n] = i_hs; in_vs_a[n] = i_vs;
      end else begin
        i_vs = 1'b0; i_hs = 1'b0; i_de = 1'b0; i_data = '0; host_bus.commit = 1'b0;
      end
    end
    fseed = fseed + 24'h010101;
  endtask

  task automatic wr(input int l, input int c, input logic [7:0] ch);
    @(posedge pclk); #1;
    host_bus.wr_en = 1'b1; host_bus.wr_line = 4'(l); host_bus.wr_col = 5'(c); host_bus.wr_char = ch;
    if (l < LINES && c < COLS) mbuf[1-mfront][l*COLS + c] = ch;
    @(posedge pclk); #1;
    host_bus.wr_en = 1'b0;
  endtask

  task automatic fill_back(input int seed);
    for (int k = 0; k < LINES*COLS; k++)
      wr(k / COLS, k % COLS, (k == 0 && seed == 0) ? 8'h41 : 8'(8'h21 + (k*7 + seed*13) % 90));
  endtask

  task automatic commit_pulse();
    @(posedge pclk); #1; host_bus.commit = 1'b1;
    @(posedge pclk); #1; host_bus.commit = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge pclk);
    #2;
    checks++; if ({o_hs, o_vs, o_de} !== 3'b000) begin errors++; $display("FAIL reset_sync: got %b expected 000", {o_hs, o_vs, o_de}); end
    checks++; if (o_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected 000000", o_data); end
    checks++; if (font_addr !== 12'h0) begin errors++; $display("FAIL reset_font_addr: got %h expected 000", font_addr); end
    checks++; if (host_bus.commit_pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b expected 0", host_bus.commit_pend); end
    rst_n = 1'b1;
    commit_pulse();
    checks++; if (host_bus.commit_pend !== 1'b1) begin errors++; $display("FAIL commit_accept: got %b expected 1", host_bus.commit_pend); end
    i_de = 1'b1; i_data = 24'h123456;
    repeat (5) @(posedge pclk);
    #1;
    checks++; if (o_de !== 1'b1 || o_data !== 24'h123456) begin errors++; $display("FAIL pre_reset_out: got de=%b data=%h expected de=1 data=123456", o_de, o_data); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (o_de !== 1'b0 || o_data !== 24'h0) begin errors++; $display("FAIL midline_reset_out: got de=%b data=%h expected de=0 data=000000", o_de, o_data); end
    checks++; if (host_bus.commit_pend !== 1'b0) begin errors++; $display("FAIL midline_reset_pend: got %b expected 0", host_bus.commit_pend); end
    i_de = 1'b0; i_data = '0;
    @(posedge pclk); #1 rst_n = 1'b1;
    mfront = 0;
  endtask

  task automatic test_write_commit();
    int e;
    fill_back(0);
    commit_pulse();
    checks++; if (host_bus.commit_pend !== 1'b1) begin errors++; $display("FAIL wc_pend_set: got %b expected 1", host_bus.commit_pend); end
    scale2x = 1'b0; opaque = 1'b0; mscale = 1'b0; mopaque = 1'b0;
    mfront = 1; mdisp = 1;
    run_frame(1'b0);
    checks++; if (cap_pend[0] !== 1'b1 || cap_pend[1] !== 1'b0) begin errors++; $display("FAIL wc_pend_fall: got %b%b expected 10", cap_pend[0], cap_pend[1]); end
    e = data_errs();
    checks++; if (e !== 0) begin errors++; $display("FAIL wc_frame_data: got %0d bad pixels (first n=%0d) expected 0", e, first_bad); end
    checks++; if (cap_data[pix(53,50)+3] !== 24'hFFFFFF) begin errors++; $display("FAIL wc_pix_53_50: got %h expected ffffff", cap_data[pix(53,50)+3]); end
    checks++; if (cap_data[pix(50,50)+3] !== in_data_a[pix(50,50)]) begin errors++; $display("FAIL wc_pix_50_50: got %h expected %h", cap_data[pix(50,50)+3], in_data_a[pix(50,50)]); end
    checks++; if (cap_data[pix(50,65)+3] !== 24'hFFFFFF) begin errors++; $display("FAIL wc_pix_50_65: got %h expected ffffff", cap_data[pix(50,65)+3]); end
    checks++; if (cap_data[pix(50,66)+3] !== in_data_a[pix(50,66)]) begin errors++; $display("FAIL wc_pix_50_66: got %h expected %h", cap_data[pix(50,66)+3], in_data_a[pix(50,66)]); end
  endtask

  task automatic test_no_commit();
    int e;
    fill_back(1);
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0);
      e = data_errs();
      checks++; if (e !== 0 || cap_pend[1] !== 1'b0) begin errors++; $display("FAIL nocommit_frame%0d: got %0d bad pixels pend=%b expected 0 pend=0", f, e, cap_pend[1]); end
    end
  endtask

  task automatic test_scale_opaque();
    int e;
    scale2x = 1'b1; opaque = 1'b1; mscale = 1'b1; mopaque = 1'b1;
    run_frame(1'b0);
    e = data_errs();
    checks++; if (e !== 0) begin errors++; $display("FAIL s2x_frame_data: got %0d bad pixels (first n=%0d) expected 0", e, first_bad); end
    checks++; if (cap_data[pix(50,50)+3] !== 24'h000000) begin errors++; $display("FAIL s2x_pix_50_50: got %h expected 000000", cap_data[pix(50,50)+3]); end
    checks++; if (cap_data[pix(52,50)+3] !== 24'h000000) begin errors++; $display("FAIL s2x_pix_52_50: got %h expected 000000", cap_data[pix(52,50)+3]); end
    checks++; if (cap_data[pix(57,51)+3] !== 24'hFFFFFF) begin errors++; $display("FAIL s2x_pix_57_51: got %h expected ffffff", cap_data[pix(57,51)+3]); end
    checks++; if (cap_data[pix(50,81)+3] !== 24'hFFFFFF) begin errors++; $display("FAIL s2x_pix_50_81: got %h expected ffffff", cap_data[pix(50,81)+3]); end
    checks++; if (cap_data[pix(50,82)+3] !== in_data_a[pix(50,82)]) begin errors++; $display("FAIL s2x_pix_50_82: got %h expected %h", cap_data[pix(50,82)+3], in_data_a[pix(50,82)]); end
    checks++; if (cap_data[pix(49,60)+3] !== in_data_a[pix(49,60)]) begin errors++; $display("FAIL s2x_pix_49_60: got %h expected %h", cap_data[pix(49,60)+3], in_data_a[pix(49,60)]); end
    scale2x = 1'b0; opaque = 1'b0; mscale = 1'b0; mopaque = 1'b0;
  endtask

  task automatic test_bounds_coincident();
    int e;
    wr(0, COLS, 8'h5A);
    wr(LINES, 0, 8'h5A);
    wr(9, 31, 8'h5A);
    wr(15, 1, 8'h5A);
    wr(0, 1, 8'h42);
    run_frame(1'b1);
    checks++; if (cap_pend[1] !== 1'b1 || cap_pend[N] !== 1'b1) begin errors++; $display("FAIL coinc_pend_hold: got %b%b expected 11", cap_pend[1], cap_pend[N]); end
    e = data_errs();
    checks++; if (e !== 0) begin errors++; $display("FAIL coinc_no_swap: got %0d bad pixels (first n=%0d) expected 0", e, first_bad); end
    mfront = 0; mdisp = 0;
    run_frame(1'b0);
    checks++; if (cap_pend[0] !== 1'b1 || cap_pend[1] !== 1'b0) begin errors++; $display("FAIL coinc_pend_fall: got %b%b expected 10", cap_pend[0], cap_pend[1]); end
    e = data_errs();
    checks++; if (e !== 0) begin errors++; $display("FAIL bounds_swap_data: got %0d bad pixels (first n=%0d) expected 0", e, first_bad); end
  endtask

  task automatic test_latency();
    int e, n0;
    n0 = pix(0, 0);
    e = sync_errs();
    checks++; if (e !== 0) begin errors++; $display("FAIL lat_sync: got %0d bad cycles expected 0", e); end
    checks++; if (cap_de[n0+2] !== 1'b0 || cap_de[n0+3] !== 1'b1) begin errors++; $display("FAIL lat_de_edge: got %b%b expected 01", cap_de[n0+2], cap_de[n0+3]); end
    checks++; if (cap_data[n0+3] !== in_data_a[n0]) begin errors++; $display("FAIL lat_data_first: got %h expected %h", cap_data[n0+3], in_data_a[n0]); end
    e = 0;
    for (int n = 0; n < pix(0, YS); n++)
      if (cap_data[n+3] !== in_data_a[n]) e++;
    checks++; if (e !== 0) begin errors++; $display("FAIL lat_ramp: got %0d bad pixels expected 0", e); end
  endtask

  initial begin
    checks = 0; errors = 0; first_bad = -1;
    fseed = 24'h100000; mfront = 0; mdisp = 0; mscale = 1'b0; mopaque = 1'b0;
    i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_data = '0; scale2x = 1'b0; opaque = 1'b0;
    host_bus.wr_en = 1'b0; host_bus.wr_line = '0; host_bus.wr_col = '0; host_bus.wr_char = '0;
    host_bus.commit = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_write_commit();
    test_no_commit();
    test_scale_opaque();
    test_bounds_coincident();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
